// File: rtl/regfile_mp_if.sv
// Register file bus: read ports, PC value, two writeback ports, busy lock and
// the error pulses. Decode/writeback drive it through the master modport; the
// register file sits on the slave modport.
interface regfile_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NUM_RD = 3
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [DATA_W-1:0]        pc;
  logic                     wa_en;
  logic [ADDR_W-1:0]        wa_addr;
  logic [DATA_W-1:0]        wa_data;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     lock_en;
  logic [ADDR_W-1:0]        lock_addr;
  logic                     wr_conflict;
  logic                     pc_wr_err;

  modport master (
    output rd_addr, pc, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, lock_en, lock_addr,
    input  rd_data, rd_busy, wr_conflict, pc_wr_err
  );

  modport slave (
    input  rd_addr, pc, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, lock_en, lock_addr,
    output rd_data, rd_busy, wr_conflict, pc_wr_err
  );

endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD registered read ports, two write ports
// (A = ALU, B = load, B wins on same address), PC aliased at PC_ADDR and a
// per-register busy scoreboard.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read
// forwarding of data and busy; without it reads see pre-write state.
module regfile_mp #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned NUM_RD  = 3,
  parameter int unsigned PC_ADDR = 15
) (
  input logic         clk_i,
  input logic         reset_n_i,
  regfile_mp_if.slave bus
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PcAddr = ADDR_W'(PC_ADDR);

  logic [DATA_W-1:0]        r_regs [NUM_REGS];
  logic [DATA_W-1:0]        w_regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]      r_busy;
  logic [NUM_REGS-1:0]      w_busy_d;
  logic [NUM_RD*DATA_W-1:0] r_rd_data;
  logic [NUM_RD-1:0]        r_rd_busy;
  logic [DATA_W-1:0]        w_rd_data [NUM_RD];
  logic [NUM_RD-1:0]        w_rd_busy;
  logic                     r_wr_conflict;
  logic                     r_pc_wr_err;
  logic                     w_we_a;
  logic                     w_we_b;
  logic                     w_conflict;
  logic                     w_pc_err;

  // Reset contents: reg0 = 0, reg1 = MSB set, others hold their own index.
  function automatic logic [DATA_W-1:0] f_reset_val(int unsigned idx);
    logic [DATA_W-1:0] v;
    if (idx == 0 || idx == PC_ADDR) begin
      v = '0;
    end else if (idx == 1) begin
      v = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      v = DATA_W'(idx);
    end
    return v;
  endfunction

  // Writes to the PC alias never reach storage.
  assign w_we_a     = bus.wa_en && (bus.wa_addr != PcAddr);
  assign w_we_b     = bus.wb_en && (bus.wb_addr != PcAddr);
  assign w_conflict = bus.wa_en && bus.wb_en && (bus.wa_addr == bus.wb_addr);
  assign w_pc_err   = (bus.wa_en && (bus.wa_addr == PcAddr)) ||
                      (bus.wb_en && (bus.wb_addr == PcAddr));

  // Next-state storage and scoreboard: B after A so B wins, lock after clear so lock wins.
  always_comb begin
    w_regs_d = r_regs;
    w_busy_d = r_busy;
    if (w_we_a) begin
      w_regs_d[bus.wa_addr] = bus.wa_data;
    end
    if (w_we_b) begin
      w_regs_d[bus.wb_addr] = bus.wb_data;
    end
    if (bus.wa_en) begin
      w_busy_d[bus.wa_addr] = 1'b0;
    end
    if (bus.wb_en) begin
      w_busy_d[bus.wb_addr] = 1'b0;
    end
    if (bus.lock_en && (bus.lock_addr != PcAddr)) begin
      w_busy_d[bus.lock_addr] = 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = bus.rd_addr[k*ADDR_W +: ADDR_W];

    // Per-port read mux: storage, optional forwarding, PC alias has final say.
    always_comb begin
      w_rd_data[k] = r_regs[w_addr];
      w_rd_busy[k] = r_busy[w_addr];
`ifdef REGFILE_BYPASS_EN
      if (w_we_a && (bus.wa_addr == w_addr)) begin
        w_rd_data[k] = bus.wa_data;
        w_rd_busy[k] = 1'b0;
      end
      if (w_we_b && (bus.wb_addr == w_addr)) begin
        w_rd_data[k] = bus.wb_data;
        w_rd_busy[k] = 1'b0;
      end
`else
`endif
      if (w_addr == PcAddr) begin
        w_rd_data[k] = bus.pc;
        w_rd_busy[k] = 1'b0;
      end
    end
  end

  // State and registered outputs; reset overrides any write or lock in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= f_reset_val(i);
      end
      r_busy        <= '0;
      r_rd_data     <= '0;
      r_rd_busy     <= '0;
      r_wr_conflict <= 1'b0;
      r_pc_wr_err   <= 1'b0;
    end else begin
      r_regs <= w_regs_d;
      r_busy <= w_busy_d;
      for (int unsigned k = 0; k < NUM_RD; k++) begin
        r_rd_data[k*DATA_W +: DATA_W] <= w_rd_data[k];
      end
      r_rd_busy     <= w_rd_busy;
      r_wr_conflict <= w_conflict;
      r_pc_wr_err   <= w_pc_err;
    end
  end

  assign bus.rd_data     = r_rd_data;
  assign bus.rd_busy     = r_rd_busy;
  assign bus.wr_conflict = r_wr_conflict;
  assign bus.pc_wr_err   = r_pc_wr_err;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with a read scoreboard: expected read results
// are queued as the read is issued and compared one clock later.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3)) bus ();

  regfile_mp #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3), .PC_ADDR(15)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int k, input int a, input logic [31:0] d, input logic b,
                    input string tag);
    exp_t e;
    bus.rd_addr[k*4 +: 4] = 4'(a);
    e.tag  = tag;
    e.port = k;
    e.data = d;
    e.busy = b;
    q.push_back(e);
  endtask

  // One clock: sample after the edge, retire queued reads, drop one-shot enables.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, "_data"}, bus.rd_data[e.port*32 +: 32], e.data);
      chk({e.tag, "_busy"}, {31'd0, bus.rd_busy[e.port]}, {31'd0, e.busy});
    end
    bus.wa_en   = 1'b0;
    bus.wb_en   = 1'b0;
    bus.lock_en = 1'b0;
  endtask

  task automatic wa(input int a, input logic [31:0] d);
    bus.wa_en = 1'b1; bus.wa_addr = 4'(a); bus.wa_data = d;
  endtask

  task automatic wb(input int a, input logic [31:0] d);
    bus.wb_en = 1'b1; bus.wb_addr = 4'(a); bus.wb_data = d;
  endtask

  task automatic lock(input int a);
    bus.lock_en = 1'b1; bus.lock_addr = 4'(a);
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.rd_addr   = '0;
    bus.pc        = '0;
    bus.wa_en     = 1'b0;
    bus.wa_addr   = '0;
    bus.wa_data   = '0;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.lock_en   = 1'b0;
    bus.lock_addr = '0;

    // Reset held two cycles; outputs forced to zero, writes/locks ignored.
    rd(0, 0, 32'h0, 1'b0, "rst0_p0"); rd(1, 1, 32'h0, 1'b0, "rst0_p1");
    rd(2, 5, 32'h0, 1'b0, "rst0_p2");
    cycle();
    wa(5, 32'h55); lock(5);
    rd(0, 0, 32'h0, 1'b0, "rst1_p0"); rd(1, 1, 32'h0, 1'b0, "rst1_p1");
    rd(2, 5, 32'h0, 1'b0, "rst1_p2");
    cycle();
    chk("rst_conflict", {31'd0, bus.wr_conflict}, 32'd0);
    chk("rst_pcerr", {31'd0, bus.pc_wr_err}, 32'd0);
    reset_n = 1'b1;
    rd(0, 0, 32'h0000_0000, 1'b0, "init_r0"); rd(1, 1, 32'h8000_0000, 1'b0, "init_r1");
    rd(2, 5, 32'h0000_0005, 1'b0, "init_r5");
    cycle();

    // PC alias and rejected PC write.
    bus.pc = 32'h0000_0040;
    rd(0, 15, 32'h40, 1'b0, "pc_read");
    cycle();
    bus.pc = 32'h0000_0044;
    wa(15, 32'hDEAD);
    rd(0, 15, 32'h44, 1'b0, "pc_rdw");
    cycle();
    chk("pc_wr_err_pulse", {31'd0, bus.pc_wr_err}, 32'd1);
    lock(15);
    rd(0, 15, 32'h44, 1'b0, "pc_after_wr");
    cycle();
    chk("pc_wr_err_clear", {31'd0, bus.pc_wr_err}, 32'd0);
    rd(0, 15, 32'h44, 1'b0, "pc_lock_ignored");
    cycle();

    // Dual-write conflict: B wins.
    wa(3, 32'h11); wb(3, 32'h22);
    rd(0, 3, Bypass ? 32'h22 : 32'h3, 1'b0, "conf_rdw");
    cycle();
    chk("conflict_pulse", {31'd0, bus.wr_conflict}, 32'd1);
    rd(0, 3, 32'h22, 1'b0, "conf_after");
    cycle();
    chk("conflict_clear", {31'd0, bus.wr_conflict}, 32'd0);
    wa(4, 32'hAA); wb(6, 32'hBB);
    rd(0, 4, Bypass ? 32'hAA : 32'h4, 1'b0, "dual_rdw4");
    rd(1, 6, Bypass ? 32'hBB : 32'h6, 1'b0, "dual_rdw6");
    cycle();
    chk("dual_no_conflict", {31'd0, bus.wr_conflict}, 32'd0);
    rd(0, 4, 32'hAA, 1'b0, "dual_r4"); rd(1, 6, 32'hBB, 1'b0, "dual_r6");
    cycle();

    // Read during write.
    wa(7, 32'h1234);
    rd(0, 7, Bypass ? 32'h1234 : 32'h7, 1'b0, "rdw7");
    cycle();
    rd(0, 7, 32'h1234, 1'b0, "rdw7_after");
    cycle();

    // Scoreboard: lock, clear by write, lock wins over write.
    lock(9);
    rd(0, 9, 32'h9, 1'b0, "sb_lock_same");
    cycle();
    rd(0, 9, 32'h9, 1'b1, "sb_busy");
    cycle();
    wb(9, 32'h99);
    rd(0, 9, Bypass ? 32'h99 : 32'h9, Bypass ? 1'b0 : 1'b1, "sb_clear_rdw");
    cycle();
    rd(0, 9, 32'h99, 1'b0, "sb_cleared");
    cycle();
    lock(9); wa(9, 32'h77);
    rd(0, 9, Bypass ? 32'h77 : 32'h99, 1'b0, "sb_lockwr_rdw");
    cycle();
    rd(0, 9, 32'h77, 1'b1, "sb_lock_wins");
    cycle();

    // Reset mid-operation discards locks and writes.
    lock(2);
    cycle();
    lock(8);
    rd(0, 2, 32'h2, 1'b1, "mid_busy2");
    cycle();
    wa(2, 32'hFFFF);
    rd(1, 8, 32'h8, 1'b1, "mid_busy8");
    cycle();
    reset_n = 1'b0;
    wb(10, 32'h1010); lock(10);
    rd(0, 2, 32'h0, 1'b0, "mid_rst_p0"); rd(1, 8, 32'h0, 1'b0, "mid_rst_p1");
    cycle();
    reset_n = 1'b1;
    rd(0, 2, 32'h2, 1'b0, "mid_r2"); rd(1, 8, 32'h8, 1'b0, "mid_r8");
    rd(2, 10, 32'hA, 1'b0, "mid_r10");
    cycle();
    rd(0, 9, 32'h9, 1'b0, "mid_r9");
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
